// File: rtl/cpld_bus_pkg.sv
// Shared definitions for the CPC Z80 bus cycle tracker: FSM encoding,
// RAM-configuration decode constants and the watchdog counter width.
package cpld_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MEM   = 3'd1,
        ST_RFSH  = 3'd2,
        ST_IOWR  = 3'd3,
        ST_IOOTH = 3'd4
    } cyc_state_e;

    localparam int unsigned WDOG_CNT_W  = 4;
    localparam int unsigned RAMBLK_W    = 6;
    localparam logic [1:0]  RAMCFG_SEL  = 2'b11;
    localparam logic [7:0]  RAMCFG_PORT = 8'h7F;

    // Only A15 is routed to the CPLD; the 0x7F port lives in the A15-low half.
    function automatic logic is_ramcfg_port(input logic a15);
        return a15 == RAMCFG_PORT[7];
    endfunction

endpackage

// File: rtl/cpld_cyc_wdog.sv
// Bus-cycle watchdog: counts clocks of a non-idle cycle (entry clock included)
// and flags the clock on which the count reaches WDOG_MAX.
module cpld_cyc_wdog
    import cpld_bus_pkg::*;
#(
    parameter int unsigned WDOG_MAX = 15
) (
    input  logic clk,
    input  logic reset_b,
    input  logic run,
    input  logic start,
    output logic expire_c
);

    logic [WDOG_CNT_W-1:0] cnt;

    assign expire_c = run && (cnt == WDOG_CNT_W'(WDOG_MAX - 1));

    // Entry loads 1 so the count equals clocks sampled since the cycle began.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            cnt <= '0;
        end else if (expire_c) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt + WDOG_CNT_W'(1);
        end else if (start) begin
            cnt <= WDOG_CNT_W'(1);
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/cpld_bus_cycle_tracker.sv
// Tracks Z80 bus cycles on the CPC bus: flags memory read/write cycles and
// commits gate-array RAM configuration writes to the RAM mapper.
module cpld_bus_cycle_tracker
    import cpld_bus_pkg::*;
#(
    parameter int unsigned WDOG_MAX = 15
) (
    input  logic                clk,
    input  logic                reset_b,
    input  logic                mreq_b,
    input  logic                iorq_b,
    input  logic                rd_b,
    input  logic                wr_b,
    input  logic                rfsh_b,
    input  logic                adr15,
    input  logic                adr14,
    input  logic [7:0]          data,
    output logic                mwr_cyc,
    output logic                mrd_cyc,
    output logic [1:0]          adr_hi_q,
    output logic [RAMBLK_W-1:0] ramblock,
    output logic                ramblock_upd,
    output logic                cyc_err
);

    cyc_state_e state;
    cyc_state_e nxt;

    logic [RAMBLK_W-1:0] pending;
    logic [RAMBLK_W-1:0] pending_d;
    logic [RAMBLK_W-1:0] ramblock_d;
    logic [1:0]          adr_hi_d;
    logic                mwr_d;
    logic                mrd_d;
    logic                upd_d;
    logic                err_d;

    logic busy;
    logic start;
    logic cfg_wr;
    logic expire_c;

    assign busy   = (state != ST_IDLE);
    assign start  = !busy && (!mreq_b || !iorq_b);
    assign cfg_wr = !wr_b && is_ramcfg_port(adr15) && (data[7:6] == RAMCFG_SEL);

    cpld_cyc_wdog #(
        .WDOG_MAX (WDOG_MAX)
    ) u_wdog (
        .clk      (clk),
        .reset_b  (reset_b),
        .run      (busy),
        .start    (start),
        .expire_c (expire_c)
    );

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state <= ST_IDLE;
        end else begin
            state <= nxt;
        end
    end

    // Next state; a watchdog expiry overrides every other transition.
    always_comb begin
        nxt = state;
        if (expire_c) begin
            nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!mreq_b) begin
                        nxt = rfsh_b ? ST_MEM : ST_RFSH;
                    end else if (!iorq_b) begin
                        nxt = cfg_wr ? ST_IOWR : ST_IOOTH;
                    end
                end
                ST_MEM, ST_RFSH: begin
                    if (mreq_b) begin
                        nxt = ST_IDLE;
                    end
                end
                ST_IOWR, ST_IOOTH: begin
                    if (iorq_b) begin
                        nxt = ST_IDLE;
                    end
                end
                default: nxt = ST_IDLE;
            endcase
        end
    end

    // Next values of the registered outputs and the pending bank register.
    always_comb begin
        mwr_d      = mwr_cyc;
        mrd_d      = mrd_cyc;
        adr_hi_d   = adr_hi_q;
        ramblock_d = ramblock;
        pending_d  = pending;
        upd_d      = 1'b0;
        err_d      = cyc_err;
        if (expire_c) begin
            mwr_d     = 1'b0;
            mrd_d     = 1'b0;
            pending_d = '0;
            err_d     = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!mreq_b) begin
                        if (rfsh_b) begin
                            adr_hi_d = {adr15, adr14};
                            mwr_d    = rd_b;
                            mrd_d    = !rd_b;
                        end
                        if (!iorq_b) begin
                            err_d = 1'b1;
                        end
                    end else if (!iorq_b && cfg_wr) begin
                        pending_d = data[5:0];
                    end
                end
                ST_MEM, ST_RFSH: begin
                    if (mreq_b) begin
                        mwr_d = 1'b0;
                        mrd_d = 1'b0;
                    end
                end
                ST_IOWR: begin
                    if (iorq_b) begin
                        ramblock_d = pending;
                        upd_d      = 1'b1;
                    end else if (!wr_b) begin
                        pending_d = data[5:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            mwr_cyc      <= 1'b0;
            mrd_cyc      <= 1'b0;
            adr_hi_q     <= 2'b00;
            ramblock     <= '0;
            ramblock_upd <= 1'b0;
            cyc_err      <= 1'b0;
            pending      <= '0;
        end else begin
            mwr_cyc      <= mwr_d;
            mrd_cyc      <= mrd_d;
            adr_hi_q     <= adr_hi_d;
            ramblock     <= ramblock_d;
            ramblock_upd <= upd_d;
            cyc_err      <= err_d;
            pending      <= pending_d;
        end
    end

endmodule

// File: tb/tb_cpld_bus_cycle_tracker.sv
// Directed bench for cpld_bus_cycle_tracker: a cycle-level bus model checked
// every clock, plus hand-computed expectations at key points.
module tb_cpld_bus_cycle_tracker;

    localparam int unsigned WDOG_MAX = 15;

    localparam int K_NONE = 0;
    localparam int K_MEM  = 1;
    localparam int K_RFSH = 2;
    localparam int K_BANK = 3;
    localparam int K_IO   = 4;

    logic       clk     = 1'b0;
    logic       reset_b = 1'b0;
    logic       mreq_b  = 1'b1;
    logic       iorq_b  = 1'b1;
    logic       rd_b    = 1'b1;
    logic       wr_b    = 1'b1;
    logic       rfsh_b  = 1'b1;
    logic       adr15   = 1'b0;
    logic       adr14   = 1'b0;
    logic [7:0] data    = 8'h00;

    logic       mwr_cyc;
    logic       mrd_cyc;
    logic [1:0] adr_hi_q;
    logic [5:0] ramblock;
    logic       ramblock_upd;
    logic       cyc_err;

    int checks     = 0;
    int passed     = 0;
    int upd_pulses = 0;

    typedef struct {
        int         kind;
        int         age;
        logic       mwr;
        logic       mrd;
        logic [1:0] adr;
        logic [5:0] ram;
        logic [5:0] pend;
        logic       upd;
        logic       err;
    } model_t;

    model_t m;

    cpld_bus_cycle_tracker #(
        .WDOG_MAX (WDOG_MAX)
    ) dut (
        .clk          (clk),
        .reset_b      (reset_b),
        .mreq_b       (mreq_b),
        .iorq_b       (iorq_b),
        .rd_b         (rd_b),
        .wr_b         (wr_b),
        .rfsh_b       (rfsh_b),
        .adr15        (adr15),
        .adr14        (adr14),
        .data         (data),
        .mwr_cyc      (mwr_cyc),
        .mrd_cyc      (mrd_cyc),
        .adr_hi_q     (adr_hi_q),
        .ramblock     (ramblock),
        .ramblock_upd (ramblock_upd),
        .cyc_err      (cyc_err)
    );

    always #5 clk = ~clk;

    function automatic model_t model_reset();
        model_t r;
        r.kind = K_NONE;
        r.age  = 0;
        r.mwr  = 1'b0;
        r.mrd  = 1'b0;
        r.adr  = 2'b00;
        r.ram  = 6'd0;
        r.pend = 6'd0;
        r.upd  = 1'b0;
        r.err  = 1'b0;
        return r;
    endfunction

    // One bus clock of the tracker's behaviour, from the sampled strobes.
    function automatic model_t model_next(input model_t c);
        model_t n = c;
        n.upd = 1'b0;
        if (c.kind != K_NONE) begin
            n.age = c.age + 1;
            if (n.age >= int'(WDOG_MAX)) begin
                n.kind = K_NONE;
                n.mwr  = 1'b0;
                n.mrd  = 1'b0;
                n.pend = 6'd0;
                n.err  = 1'b1;
            end else if ((c.kind == K_MEM || c.kind == K_RFSH) && mreq_b) begin
                n.kind = K_NONE;
                n.mwr  = 1'b0;
                n.mrd  = 1'b0;
            end else if (c.kind == K_BANK) begin
                if (iorq_b) begin
                    n.ram  = c.pend;
                    n.upd  = 1'b1;
                    n.kind = K_NONE;
                end else if (!wr_b) begin
                    n.pend = data[5:0];
                end
            end else if (c.kind == K_IO && iorq_b) begin
                n.kind = K_NONE;
            end
        end else if (!mreq_b) begin
            n.age = 1;
            if (!iorq_b) n.err = 1'b1;
            if (rfsh_b) begin
                n.kind = K_MEM;
                n.adr  = {adr15, adr14};
                n.mwr  = rd_b;
                n.mrd  = !rd_b;
            end else begin
                n.kind = K_RFSH;
            end
        end else if (!iorq_b) begin
            n.age = 1;
            if (!wr_b && !adr15 && data[7] && data[6]) begin
                n.kind = K_BANK;
                n.pend = data[5:0];
            end else begin
                n.kind = K_IO;
            end
        end
        return n;
    endfunction

    initial m = model_reset();

    always @(posedge clk or negedge reset_b) begin
        if (!reset_b) m <= model_reset();
        else          m <= model_next(m);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Every-cycle comparison of {mwr,mrd,adr_hi,ramblock,upd,err} against the model.
    always @(posedge clk) begin
        #1;
        check("cycle_outputs",
              32'({mwr_cyc, mrd_cyc, adr_hi_q, ramblock, ramblock_upd, cyc_err}),
              32'({m.mwr, m.mrd, m.adr, m.ram, m.upd, m.err}));
        if (ramblock_upd) upd_pulses++;
    end

    task automatic bus(input logic mq, input logic iq, input logic rd, input logic wr,
                       input logic rf, input logic a15, input logic a14,
                       input logic [7:0] d, input int n);
        mreq_b = mq;
        iorq_b = iq;
        rd_b   = rd;
        wr_b   = wr;
        rfsh_b = rf;
        adr15  = a15;
        adr14  = a14;
        data   = d;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, n);
    endtask

    task automatic pulse_reset();
        reset_b = 1'b0;
        @(negedge clk);
        reset_b = 1'b1;
        idle(2);
    endtask

    initial begin
        int p0;
        @(negedge clk);
        idle(2);
        check("reset_outputs", 32'({mwr_cyc, mrd_cyc, adr_hi_q, ramblock, ramblock_upd, cyc_err}), 32'h0);
        reset_b = 1'b1;

        // Memory write at 0x4xxx, first strobe after reset
        bus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1);
        check("memwr_edge1", 32'({mwr_cyc, mrd_cyc}), 32'b10);
        check("memwr_adr_hi", 32'(adr_hi_q), 32'b01);
        bus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 2);
        check("memwr_held", 32'(mwr_cyc), 32'd1);
        idle(1);
        check("memwr_release", 32'({mwr_cyc, mrd_cyc, adr_hi_q}), 32'b0001);

        // Memory read at 0x8xxx
        bus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 2);
        check("memrd", 32'({mwr_cyc, mrd_cyc, adr_hi_q}), 32'b0110);
        idle(1);

        // Bank select with a re-captured data byte: 0xFF then 0xD1
        bus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 1);
        bus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hD1, 1);
        bus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hD1, 1);
        check("bank_commit", 32'({ramblock, ramblock_upd}), 32'b0100011);
        idle(1);
        check("bank_pulse_end", 32'({ramblock, ramblock_upd}), 32'b0100010);

        // Non-matching IO: select code 10, IO read, A15 high
        p0 = upd_pulses;
        bus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h91, 2);
        idle(1);
        bus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 2);
        idle(1);
        bus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hC2, 2);
        idle(1);
        check("io_other_ramblock", 32'(ramblock), 32'b010001);
        check("io_other_no_pulse", 32'(upd_pulses - p0), 32'd0);

        // Refresh, then a normal cycle decodes again
        bus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2);
        check("rfsh_flags", 32'({mwr_cyc, mrd_cyc, adr_hi_q}), 32'b0010);
        idle(1);
        bus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1);
        check("after_rfsh_memwr", 32'({mwr_cyc, adr_hi_q}), 32'b111);
        idle(1);
        check("no_err_yet", 32'(cyc_err), 32'd0);

        // Watchdog: mreq_b low for 20 clocks
        bus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 14);
        check("wdog_before", 32'({mwr_cyc, cyc_err}), 32'b10);
        bus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1);
        check("wdog_expire", 32'({mwr_cyc, cyc_err}), 32'b01);
        bus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 5);
        idle(2);
        check("wdog_err_sticky", 32'(cyc_err), 32'd1);

        pulse_reset();
        check("reset_clears_err", 32'({ramblock, cyc_err}), 32'd0);

        // Reset in the middle of a bank-select write
        p0 = upd_pulses;
        bus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 2);
        reset_b = 1'b0;
        @(negedge clk);
        reset_b = 1'b1;
        idle(3);
        check("rst_mid_iowr_ramblock", 32'(ramblock), 32'd0);
        check("rst_mid_iowr_no_pulse", 32'(upd_pulses - p0), 32'd0);

        // Simultaneous mreq_b/iorq_b after a committed bank 0x11
        bus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hD1, 2);
        idle(1);
        p0 = upd_pulses;
        bus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hE3, 2);
        check("simul_mem_err", 32'({mwr_cyc, cyc_err}), 32'b11);
        idle(2);
        check("simul_ramblock", 32'(ramblock), 32'b010001);
        check("simul_no_pulse", 32'(upd_pulses - p0), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/cpld_bus_cycle_tracker.md
CPLD_BUS_CYCLE_TRACKER -- requirements
Module: cpld_bus_cycle_tracker

Interface
REQ-001 SHALL have parameter WDOG_MAX, default 15, meaning the clk count after which a non-idle cycle is aborted.
REQ-002 clk  input  1  CPC 4 MHz bus clock; all state updates on rising edge.
REQ-003 reset_b  input  1  asynchronous, active-low reset.
REQ-004 mreq_b, iorq_b, rd_b, wr_b, rfsh_b  input  1 each  Z80 bus strobes, active-low.
REQ-005 adr15, adr14  input  1 each  Z80 address bits.
REQ-006 data  input  8  Z80 data bus.
REQ-007 mwr_cyc  output  1  memory write cycle in progress.
REQ-008 mrd_cyc  output  1  memory read cycle in progress.
REQ-009 adr_hi_q  output  2  {adr15,adr14} latched at cycle start.
REQ-010 ramblock  output  6  committed bank/scheme register {ccc,bbb} for the RAM mapper.
REQ-011 ramblock_upd  output  1  one-clk pulse on ramblock commit.
REQ-012 cyc_err  output  1  sticky protocol error flag.

Function
REQ-013 SHALL implement FSM states IDLE, MEM, RFSH, IOWR, IOOTH.
REQ-014 From IDLE, if !mreq_b & rfsh_b: go to MEM and latch adr_hi_q <= {adr15,adr14}.
REQ-015 On IDLE->MEM, mwr_cyc SHALL be set when rd_b=1, else mrd_cyc SHALL be set; never both.
REQ-016 From IDLE, if !mreq_b & !rfsh_b: go to RFSH; mwr_cyc, mrd_cyc stay 0.
REQ-017 From IDLE, if !iorq_b & !wr_b & !adr15 & data[7:6]==2'b11: go to IOWR and capture data[5:0] into a pending register.
REQ-018 From IDLE, any other !iorq_b: go to IOOTH; no register effect.
REQ-019 In IOWR, pending SHALL re-capture data[5:0] each clk while wr_b=0.
REQ-020 MEM and RFSH SHALL return to IDLE on the first clk with mreq_b=1; mwr_cyc/mrd_cyc clear on the same edge.
REQ-021 IOWR SHALL return to IDLE on the first clk with iorq_b=1, committing ramblock <= pending and pulsing ramblock_upd for exactly that one clk.
REQ-022 IOOTH SHALL return to IDLE on the first clk with iorq_b=1.
REQ-023 If mreq_b and iorq_b are both low in IDLE, MEM takes priority and cyc_err SHALL be set.
REQ-024 A 4-bit watchdog SHALL count clks in any non-IDLE state, clearing on entry to IDLE; on reaching WDOG_MAX, the FSM SHALL force IDLE, clear mwr_cyc/mrd_cyc, discard pending without commit, and set cyc_err.
REQ-025 cyc_err SHALL be cleared only by reset.
REQ-026 Latency: mwr_cyc/mrd_cyc assert one clk edge after mreq_b falls; ramblock is visible one edge after iorq_b rises.

Reset
REQ-027 reset_b low SHALL immediately force IDLE, with outputs mwr_cyc=0, mrd_cyc=0, adr_hi_q=2'b00, ramblock=6'b000000, ramblock_upd=0, cyc_err=0, and pending=0.
REQ-028 Reset asserted mid-IOWR SHALL discard pending; ramblock SHALL remain 0 after release.
REQ-029 The first bus strobe sampled after reset_b rises SHALL be decoded from IDLE normally.

Structure
REQ-030 The state encodings, the 2'b11 select code and the 0x7F port match constant SHALL reside in shared package cpld_bus_pkg.
REQ-031 The watchdog SHALL be a sub-module cpld_cyc_wdog (counter, clear, expire output); all other logic stays flat.

Verification
REQ-032 Memory write: mreq_b low, rd_b=1, adr15/14=01, held 3 clks -> mwr_cyc=1 from edge 1 to release, adr_hi_q=01, mrd_cyc=0.
REQ-033 Bank select: IO write to 0x7F00 with data 0xD1 -> after iorq_b rises, ramblock=6'b010001 and ramblock_upd pulses 1 clk; data 0x91 -> ramblock unchanged.
REQ-034 Refresh: mreq_b and rfsh_b both low for 2 clks -> state RFSH, mwr_cyc=mrd_cyc=0, return to IDLE.
REQ-035 Watchdog: mreq_b held low for 20 clks -> forced IDLE at clk 15, mwr_cyc cleared, cyc_err=1 persisting until reset.
REQ-036 Reset mid-IOWR: data 0xFF write, reset_b pulsed before iorq_b rises -> ramblock=0, ramblock_upd never pulses.
REQ-037 Simultaneous mreq_b/iorq_b low -> MEM entered, cyc_err=1, ramblock unchanged.
